// File: rtl/arb_pkg.sv
// Shared constants, state encoding and helpers for the 8-way round-robin arbiter.
package arb_pkg;
  localparam int N_REQ = 8;
  localparam int IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

  function automatic logic [N_REQ-1:0] onehot8(input logic [IDX_W-1:0] idx);
    logic [N_REQ-1:0] v;
    v      = '0;
    v[idx] = 1'b1;
    return v;
  endfunction
endpackage

// File: rtl/rr_arbiter8_if.sv
// Client-side request/grant bundle shared between the arbiter and its clients.
interface rr_arbiter8_if;
  import arb_pkg::*;

  logic [N_REQ-1:0] req;
  logic             done;
  logic [N_REQ-1:0] gnt;
  logic [IDX_W-1:0] gnt_id;
  logic             gnt_valid;
  logic             timeout;

  modport master (
    output req, done,
    input  gnt, gnt_id, gnt_valid, timeout
  );

  modport slave (
    input  req, done,
    output gnt, gnt_id, gnt_valid, timeout
  );
endinterface

// File: rtl/rr_prio_enc8.sv
// Rotating-priority encoder: first set request strictly after ptr, wrapping modulo 8.
module rr_prio_enc8
  import arb_pkg::*;
(
  input  logic [N_REQ-1:0] req,
  input  logic [IDX_W-1:0] ptr,
  output logic [IDX_W-1:0] idx,
  output logic             any_valid
);
  logic [IDX_W-1:0]   offset;
  logic [2*N_REQ-1:0] dbl;
  logic [N_REQ-1:0]   rot;
  logic [IDX_W-1:0]   low;

  always_comb begin
    offset = ptr + IDX_W'(1);
    // rot[k] holds req[(k+offset) mod 8], so bit 0 is the highest-priority client
    dbl    = {req, req};
    rot    = dbl[offset +: N_REQ];
    low    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      if (rot[k]) low = IDX_W'(k);
    end
    idx       = low + offset;
    any_valid = |req;
  end
endmodule

// File: rtl/rr_arbiter8.sv
// 8-requester round-robin arbiter with registered grant, done/drop release and optional hold timeout.
module rr_arbiter8
  import arb_pkg::*;
#(
  parameter int MAX_HOLD = 0,
  parameter int HOLD_W   = 8
) (
  input logic          clk,
  input logic          rst,
  rr_arbiter8_if.slave bus
);
  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'((MAX_HOLD > 0) ? MAX_HOLD - 1 : 0);
  localparam bit                HOLD_EN   = (MAX_HOLD != 0);

  state_t           state, state_nx;
  logic [IDX_W-1:0] ptr, ptr_nx;
  logic [IDX_W-1:0] id_q, id_nx;
  logic [IDX_W-1:0] win;
  logic [N_REQ-1:0] gnt_q, gnt_nx;
  logic             valid_q, valid_nx;
  logic             to_q, to_nx;
  logic [HOLD_W-1:0] hold_cnt, hold_nx;
  logic             any_req, owner_req, hold_limit, release_now;

  rr_prio_enc8 u_enc (
    .req       (bus.req),
    .ptr       (ptr),
    .idx       (win),
    .any_valid (any_req)
  );

  assign owner_req   = bus.req[id_q];
  assign hold_limit  = HOLD_EN && (hold_cnt == HOLD_LAST);
  assign release_now = bus.done | ~owner_req | hold_limit;

  always_comb begin
    state_nx = state;
    ptr_nx   = ptr;
    id_nx    = id_q;
    gnt_nx   = gnt_q;
    valid_nx = valid_q;
    hold_nx  = hold_cnt;
    to_nx    = 1'b0;
    case (state)
      IDLE: begin
        if (any_req) begin
          gnt_nx   = onehot8(win);
          id_nx    = win;
          valid_nx = 1'b1;
          ptr_nx   = win;
          hold_nx  = '0;
          state_nx = GRANT;
        end
      end
      GRANT: begin
        if (release_now) begin
          gnt_nx   = '0;
          id_nx    = '0;
          valid_nx = 1'b0;
          hold_nx  = '0;
          state_nx = IDLE;
          // Flag only revocations the owner did not ask for
          to_nx    = hold_limit & ~bus.done & owner_req;
        end else begin
          hold_nx = hold_cnt + HOLD_W'(1);
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= IDLE;
      ptr      <= IDX_W'(N_REQ - 1);
      id_q     <= '0;
      gnt_q    <= '0;
      valid_q  <= 1'b0;
      hold_cnt <= '0;
      to_q     <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      id_q     <= id_nx;
      gnt_q    <= gnt_nx;
      valid_q  <= valid_nx;
      hold_cnt <= hold_nx;
      to_q     <= to_nx;
    end
  end

  assign bus.gnt       = gnt_q;
  assign bus.gnt_id    = id_q;
  assign bus.gnt_valid = valid_q;
  assign bus.timeout   = to_q;
endmodule
